// File: rtl/capture_buffer_ctrl.sv
// Sample-capture buffer: DEPTH x NB_DATA memory with one-shot or pre-trigger
// circular capture, followed by an oldest-first readout.
module capture_buffer_ctrl #(
  parameter int NB_DATA    = 14,
  parameter int NB_ADDR    = 11,
  parameter int POST_DEPTH = 1024
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_valid,
  input  logic               i_arm,
  input  logic               i_mode,
  input  logic               i_trigger,
  input  logic               i_read_enable,
  input  logic               i_read_restart,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_data_valid,
  output logic               o_read_last,
  output logic               o_full,
  output logic               o_triggered,
  output logic [1:0]         o_state,
  output logic [NB_ADDR-1:0] o_start_addr
);

  localparam int DEPTH = 2**NB_ADDR;
  localparam logic [NB_ADDR:0]   C_DEPTH    = (NB_ADDR+1)'(DEPTH);
  localparam logic [NB_ADDR:0]   C_PRE      = (NB_ADDR+1)'(DEPTH - POST_DEPTH);
  localparam logic [NB_ADDR:0]   C_POST     = (NB_ADDR+1)'(POST_DEPTH);
  localparam logic [NB_ADDR:0]   C_ONE      = {{NB_ADDR{1'b0}}, 1'b1};
  localparam logic [NB_ADDR:0]   C_ZERO     = {(NB_ADDR+1){1'b0}};
  localparam logic [NB_ADDR-1:0] C_ADDR_ONE = {{(NB_ADDR-1){1'b0}}, 1'b1};
  localparam logic [NB_ADDR-1:0] C_ADDR_0   = {NB_ADDR{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FILL     = 3'd1,
    S_PRETRIG  = 3'd2,
    S_POSTTRIG = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  // DONE is reported with the IDLE code; o_full tells them apart.
  function automatic logic [1:0] f_state_code(input state_t s);
    case (s)
      S_FILL:     f_state_code = 2'd1;
      S_PRETRIG:  f_state_code = 2'd2;
      S_POSTTRIG: f_state_code = 2'd3;
      default:    f_state_code = 2'd0;
    endcase
  endfunction

  state_t              r_state;
  state_t              w_next_state;
  logic                r_arm_d;
  logic [NB_ADDR-1:0]  r_wr_ptr;
  logic [NB_ADDR:0]    r_wr_cnt;
  logic [NB_ADDR:0]    r_post_cnt;
  logic [NB_ADDR-1:0]  r_rd_ptr;
  logic [NB_ADDR:0]    r_rd_cnt;
  logic [NB_ADDR-1:0]  r_start_addr;
  logic [NB_DATA-1:0]  r_data;
  logic                r_data_valid;
  logic                r_read_last;
  logic                r_full;
  logic                r_triggered;
  logic [1:0]          r_state_out;
  logic [NB_DATA-1:0]  r_mem [DEPTH];

  logic                w_arm_ok;
  logic                w_wr_en;
  logic                w_trig_ok;
  logic                w_enter_done;
  logic                w_rd_ok;
  logic [NB_ADDR-1:0]  w_wr_ptr_nxt;

  assign w_arm_ok     = i_arm && !r_arm_d && (r_state == S_IDLE || r_state == S_DONE);
  assign w_wr_en      = i_valid && (r_state == S_FILL || r_state == S_PRETRIG ||
                                    r_state == S_POSTTRIG);
  assign w_trig_ok    = (r_state == S_PRETRIG) && i_trigger && (r_wr_cnt == C_PRE);
  assign w_wr_ptr_nxt = r_wr_ptr + C_ADDR_ONE;
  assign w_enter_done = (w_next_state == S_DONE) && (r_state != S_DONE);
  assign w_rd_ok      = (r_state == S_DONE) && !w_arm_ok && !i_read_restart &&
                        i_read_enable && (r_rd_cnt < C_DEPTH);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_arm_ok) w_next_state = i_mode ? S_PRETRIG : S_FILL;
        else          w_next_state = r_state;
      end
      S_FILL: begin
        if (i_valid && r_wr_cnt == C_DEPTH - C_ONE) w_next_state = S_DONE;
        else                                        w_next_state = S_FILL;
      end
      S_PRETRIG: begin
        // A valid sample on the trigger cycle is already post sample 1.
        if (w_trig_ok) begin
          if (i_valid && C_POST == C_ONE) w_next_state = S_DONE;
          else                            w_next_state = S_POSTTRIG;
        end else begin
          w_next_state = S_PRETRIG;
        end
      end
      S_POSTTRIG: begin
        if (i_valid && r_post_cnt == C_POST - C_ONE) w_next_state = S_DONE;
        else                                         w_next_state = S_POSTTRIG;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_ff @(posedge clock) begin
    if (w_wr_en && !i_reset) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_arm_d      <= 1'b1;
      r_wr_ptr     <= C_ADDR_0;
      r_wr_cnt     <= C_ZERO;
      r_post_cnt   <= C_ZERO;
      r_rd_ptr     <= C_ADDR_0;
      r_rd_cnt     <= C_ZERO;
      r_start_addr <= C_ADDR_0;
      r_data       <= {NB_DATA{1'b0}};
      r_data_valid <= 1'b0;
      r_read_last  <= 1'b0;
      r_full       <= 1'b0;
      r_triggered  <= 1'b0;
      r_state_out  <= 2'd0;
    end else begin
      r_arm_d      <= i_arm;
      r_state_out  <= f_state_code(w_next_state);
      r_data_valid <= 1'b0;
      r_read_last  <= 1'b0;
      if (w_arm_ok) begin
        r_wr_ptr    <= C_ADDR_0;
        r_wr_cnt    <= C_ZERO;
        r_post_cnt  <= C_ZERO;
        r_full      <= 1'b0;
        r_triggered <= 1'b0;
      end else begin
        if (w_wr_en) r_wr_ptr <= w_wr_ptr_nxt;
        // r_wr_cnt counts fill writes in FILL and saturating pre samples in PRETRIG.
        if (w_wr_en && r_state == S_FILL) r_wr_cnt <= r_wr_cnt + C_ONE;
        if (w_wr_en && r_state == S_PRETRIG && r_wr_cnt != C_PRE) r_wr_cnt <= r_wr_cnt + C_ONE;
        if (w_trig_ok) begin
          r_triggered <= 1'b1;
          r_post_cnt  <= i_valid ? C_ONE : C_ZERO;
        end
        if (w_wr_en && r_state == S_POSTTRIG) r_post_cnt <= r_post_cnt + C_ONE;
        if (w_enter_done) begin
          r_full       <= 1'b1;
          r_start_addr <= w_wr_ptr_nxt;
          r_rd_ptr     <= w_wr_ptr_nxt;
          r_rd_cnt     <= C_ZERO;
        end
        if (r_state == S_DONE && i_read_restart) begin
          r_rd_ptr <= r_start_addr;
          r_rd_cnt <= C_ZERO;
        end else if (w_rd_ok) begin
          r_data       <= r_mem[r_rd_ptr];
          r_data_valid <= 1'b1;
          r_read_last  <= (r_rd_cnt == C_DEPTH - C_ONE);
          r_rd_ptr     <= r_rd_ptr + C_ADDR_ONE;
          r_rd_cnt     <= r_rd_cnt + C_ONE;
        end
      end
    end
  end

  assign o_data       = r_data;
  assign o_data_valid = r_data_valid;
  assign o_read_last  = r_read_last;
  assign o_full       = r_full;
  assign o_triggered  = r_triggered;
  assign o_state      = r_state_out;
  assign o_start_addr = r_start_addr;

endmodule

// File: tb/tb_capture_buffer_ctrl.sv
// Self-checking bench for capture_buffer_ctrl: directed capture/readout scenarios,
// a table of reset/arm vectors and randomized captures against a queue model.
module tb_capture_buffer_ctrl;
  localparam int NB_DATA    = 8;
  localparam int NB_ADDR    = 4;
  localparam int POST_DEPTH = 4;
  localparam int DEPTH      = 16;

  logic               clock = 1'b0;
  logic               i_reset, i_valid, i_arm, i_mode, i_trigger;
  logic               i_read_enable, i_read_restart;
  logic [NB_DATA-1:0] i_data;
  logic [NB_DATA-1:0] o_data;
  logic               o_data_valid, o_read_last, o_full, o_triggered;
  logic [1:0]         o_state;
  logic [NB_ADDR-1:0] o_start_addr;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_words [16];
  logic [7:0] hist [$];

  typedef struct packed {
    logic       rst;
    logic       arm;
    logic       mode;
    logic       valid;
    logic [1:0] st;
    logic       full;
    logic       trig;
  } vec_t;
  vec_t vecs [8];

  capture_buffer_ctrl #(
    .NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .POST_DEPTH(POST_DEPTH)
  ) dut (
    .clock(clock), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
    .i_arm(i_arm), .i_mode(i_mode), .i_trigger(i_trigger),
    .i_read_enable(i_read_enable), .i_read_restart(i_read_restart),
    .o_data(o_data), .o_data_valid(o_data_valid), .o_read_last(o_read_last),
    .o_full(o_full), .o_triggered(o_triggered), .o_state(o_state),
    .o_start_addr(o_start_addr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    i_valid = 1'b0; i_trigger = 1'b0; i_read_enable = 1'b0; i_read_restart = 1'b0;
  endtask

  task automatic arm_capture(input logic m);
    quiet();
    i_arm = 1'b0; tick();
    i_arm = 1'b1; i_mode = m; tick();
  endtask

  task automatic push(input logic [7:0] d, input logic t);
    i_valid = 1'b1; i_data = d; i_trigger = t; tick();
    i_valid = 1'b0; i_trigger = 1'b0;
  endtask

  task automatic read_check(input string name);
    for (int i = 0; i < 16; i++) begin
      i_read_enable = 1'b1; tick();
      chk({name, "_valid"}, o_data_valid, 1);
      chk({name, "_data"}, o_data, exp_words[i]);
      chk({name, "_last"}, o_read_last, (i == 15) ? 1 : 0);
    end
    i_read_enable = 1'b0;
  endtask

  initial begin
    int m, npre, post, idx;
    logic trg, done, rd;
    logic [7:0] d;
    logic t;

    quiet();
    i_reset = 1'b1; i_arm = 1'b1; i_mode = 1'b0; i_data = 8'h00;
    tick(); tick();
    chk("rst_state", o_state, 0);
    chk("rst_full", o_full, 0);
    chk("rst_trig", o_triggered, 0);
    chk("rst_valid", o_data_valid, 0);
    chk("rst_last", o_read_last, 0);
    chk("rst_data", o_data, 0);
    chk("rst_start", o_start_addr, 0);
    i_reset = 1'b0; tick(); tick();
    chk("arm_high_thru_reset", o_state, 0);

    // Test 1: one-shot fill with gaps.
    arm_capture(1'b0);
    chk("t1_state_fill", o_state, 1);
    for (int i = 0; i < 16; i++) begin
      if (i % 3 == 0) begin i_valid = 1'b0; tick(); end
      push(8'(i), 1'b1);
      if (i == 14) chk("t1_not_full", o_full, 0);
    end
    chk("t1_full", o_full, 1);
    chk("t1_start", o_start_addr, 0);
    chk("t1_state_done", o_state, 0);
    for (int i = 0; i < 16; i++) exp_words[i] = 8'(i);
    read_check("t1_rd");
    i_read_enable = 1'b1; tick();
    chk("t1_17th_read", o_data_valid, 0);
    i_read_enable = 1'b0;

    // Test 2: pre-trigger capture, early trigger ignored.
    arm_capture(1'b1);
    chk("t2_state_pre", o_state, 2);
    for (int i = 0; i < 24; i++) begin
      push(8'(i), (i == 5 || i == 20));
      if (i == 5)  begin chk("t2_early_trig", o_triggered, 0); chk("t2_early_st", o_state, 2); end
      if (i == 20) begin chk("t2_trig", o_triggered, 1); chk("t2_post_st", o_state, 3); end
      if (i == 22) chk("t2_not_full", o_full, 0);
    end
    chk("t2_full", o_full, 1);
    chk("t2_start", o_start_addr, 8);
    for (int i = 0; i < 16; i++) exp_words[i] = 8'(8 + i);
    read_check("t2_rd");

    // Test 4: restart, partial read, restart colliding with read.
    i_read_restart = 1'b1; tick(); i_read_restart = 1'b0;
    for (int i = 0; i < 5; i++) begin
      i_read_enable = 1'b1; tick();
      chk("t4_data", o_data, exp_words[i]);
      chk("t4_valid", o_data_valid, 1);
    end
    i_read_restart = 1'b1; tick();
    chk("t4_restart_wins", o_data_valid, 0);
    i_read_restart = 1'b0; tick();
    chk("t4_after_restart_valid", o_data_valid, 1);
    chk("t4_after_restart_data", o_data, 8'h08);
    i_read_enable = 1'b0;

    // Test 3: trigger with no valid sample, then the four post samples.
    arm_capture(1'b1);
    for (int i = 0; i < 12; i++) push(8'(8'h30 + i), 1'b0);
    i_trigger = 1'b1; tick(); i_trigger = 1'b0;
    chk("t3_trig_next", o_triggered, 1);
    chk("t3_state_post", o_state, 3);
    for (int i = 0; i < 4; i++) begin
      push(8'(8'h40 + i), 1'b0);
      if (i == 2) chk("t3_not_full", o_full, 0);
    end
    chk("t3_full", o_full, 1);
    chk("t3_start", o_start_addr, 0);
    for (int i = 0; i < 12; i++) exp_words[i] = 8'(8'h30 + i);
    for (int i = 0; i < 4; i++) exp_words[12 + i] = 8'(8'h40 + i);
    read_check("t3_rd");

    // Test 5/6: reset in POSTTRIG, arm edge handling, table-driven.
    arm_capture(1'b1);
    for (int i = 0; i < 12; i++) push(8'(i), 1'b0);
    push(8'h50, 1'b1);
    push(8'h51, 1'b0);
    chk("t5_in_post", o_state, 3);
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      i_reset = vecs[i].rst; i_arm = vecs[i].arm; i_mode = vecs[i].mode;
      i_valid = vecs[i].valid; i_data = 8'h60;
      tick();
      chk($sformatf("vec%0d_state", i), o_state, vecs[i].st);
      chk($sformatf("vec%0d_full", i), o_full, vecs[i].full);
      chk($sformatf("vec%0d_trig", i), o_triggered, vecs[i].trig);
    end
    quiet(); i_reset = 1'b0;

    for (int c = 0; c < 40 && !o_full; c++) push(8'(c), 1'b1);
    chk("t6_reached_done", o_full, 1);
    i_read_enable = 1'b1; tick();
    chk("t6_read_started", o_data_valid, 1);
    i_arm = 1'b0; tick();
    i_arm = 1'b1; i_mode = 1'b0; tick();
    chk("t6_rearm_state", o_state, 1);
    chk("t6_rearm_full", o_full, 0);
    chk("t6_rearm_valid", o_data_valid, 0);
    quiet();

    // Randomized captures against a history-queue model.
    i_reset = 1'b1; tick(); i_reset = 1'b0;
    for (int run = 0; run < 8; run++) begin
      m = int'($urandom_range(0, 1));
      arm_capture(m[0]);
      chk("rnd_arm_state", o_state, m ? 2 : 1);
      hist.delete(); npre = 0; post = 0; trg = 1'b0; done = 1'b0;
      for (int c = 0; c < 600 && !done; c++) begin
        i_valid = ($urandom_range(0, 3) != 0);
        d = 8'($urandom_range(0, 255));
        t = ($urandom_range(0, 4) == 0);
        i_data = d; i_trigger = t;
        if (m == 0) begin
          if (i_valid) hist.push_back(d);
          if (hist.size() == DEPTH) done = 1'b1;
        end else if (!trg) begin
          if (t && npre >= DEPTH - POST_DEPTH) begin
            trg = 1'b1;
            if (i_valid) begin hist.push_back(d); post = 1; end
          end else if (i_valid) begin
            hist.push_back(d); npre++;
          end
        end else if (i_valid) begin
          hist.push_back(d); post++;
        end
        if (m == 1 && post == POST_DEPTH) done = 1'b1;
        tick();
        chk("rnd_full", o_full, done);
        chk("rnd_trig", o_triggered, trg);
        chk("rnd_state", o_state, done ? 0 : (m == 0) ? 1 : trg ? 3 : 2);
      end
      quiet();
      chk("rnd_capture_finished", done, 1);
      if (done) begin
        chk("rnd_start", o_start_addr, hist.size() % DEPTH);
        for (int i = 0; i < 16; i++)
          exp_words[i] = (m == 0) ? hist[i] : hist[hist.size() - DEPTH + i];
        idx = 0;
        for (int c = 0; c < 200 && idx < 16; c++) begin
          rd = ($urandom_range(0, 2) != 0);
          i_read_enable = rd; tick();
          chk("rnd_rd_valid", o_data_valid, rd);
          if (rd) begin
            chk("rnd_rd_data", o_data, exp_words[idx]);
            chk("rnd_rd_last", o_read_last, (idx == 15) ? 1 : 0);
            idx++;
          end
        end
        i_read_enable = 1'b0;
        chk("rnd_read_finished", idx, 16);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
